// File: rtl/cache_sim_pf_core.sv
// Set-associative cache-tag simulator with a next-N-line prefetcher.
// Processes one trace address at a time and keeps saturating hit/miss/prefetch statistics.
module cache_sim_pf_core #(
   parameter int unsigned way             = 4,
   parameter int unsigned block_size_byte = 16,
   parameter int unsigned cache_size_byte = 32768,
   parameter int unsigned addr_w          = 32,
   parameter int unsigned pf_degree       = 1,
   parameter int unsigned repl_mode       = 0,
   parameter int unsigned cnt_w           = 20
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              trace_ready,
   input  logic [addr_w-1:0] mem_addr,
   output logic              busy,
   output logic              updated,
   output logic              found_in_cache,
   output logic [cnt_w-1:0]  cache_hit_count,
   output logic [cnt_w-1:0]  cache_miss_count,
   output logic [cnt_w-1:0]  pf_issue_count,
   output logic [cnt_w-1:0]  pf_useful_count
);
   localparam int unsigned OFF_W = $clog2(block_size_byte);
   localparam int unsigned SETS  = cache_size_byte / (block_size_byte * way);
   localparam int unsigned IDX_W = $clog2(SETS);
   localparam int unsigned BLK_W = addr_w - OFF_W;
   localparam int unsigned TAG_W = BLK_W - IDX_W;
   localparam int unsigned WAY_W = (way > 1) ? $clog2(way) : 1;
   localparam int unsigned K_W   = $clog2(pf_degree + 2);
   localparam bit          PF_EN = (pf_degree != 0);
   localparam bit          LRU   = (repl_mode == 0);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_LOOKUP  = 3'd1;
   localparam logic [2:0] S_UPDATE  = 3'd2;
   localparam logic [2:0] S_PF_LOOK = 3'd3;
   localparam logic [2:0] S_PF_FILL = 3'd4;

   logic [2:0]       state_q, state_d;
   logic [BLK_W-1:0] base_q, base_d, cur_q, cur_d;
   logic [K_W-1:0]   k_q, k_d;
   logic             hit_q, hit_d;
   logic [WAY_W-1:0] hit_way_q, hit_way_d;
   logic             busy_q, updated_q, updated_d, found_q, found_d;
   logic [cnt_w-1:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;
   logic [cnt_w-1:0] issue_q, issue_d, useful_q, useful_d;

   // Per-set line state; ord_q[s][0] is the MRU way, ord_q[s][way-1] the LRU way.
   logic [way-1:0]   valid_q [SETS];
   logic [way-1:0]   pf_q    [SETS];
   logic [TAG_W-1:0] tag_q   [SETS][way];
   logic [WAY_W-1:0] ord_q   [SETS][way];

   logic [IDX_W-1:0] set_c;
   logic [TAG_W-1:0] tag_c;
   logic             hit_c, inv_found_c;
   logic [WAY_W-1:0] hit_way_c, vic_c;
   logic             wr_en_c, wr_pf_c, clr_pf_c, touch_c;
   logic [WAY_W-1:0] wr_way_c, touch_way_c;
   logic [WAY_W-1:0] new_ord_c [way];
   int               pos_c;

   function automatic logic [cnt_w-1:0] sat_inc(input logic [cnt_w-1:0] v);
      return (&v) ? v : v + cnt_w'(1);
   endfunction

   assign set_c = cur_q[IDX_W-1:0];
   assign tag_c = cur_q[BLK_W-1:IDX_W];

   // Tag probe and victim choice for the set currently addressed by cur_q.
   always_comb begin
      hit_c       = 1'b0;
      hit_way_c   = '0;
      inv_found_c = 1'b0;
      vic_c       = ord_q[set_c][way-1];
      for (int w = 0; w < int'(way); w++) begin
         if (valid_q[set_c][w] && (tag_q[set_c][w] == tag_c)) begin
            hit_c     = 1'b1;
            hit_way_c = WAY_W'(w);
         end
         if (!inv_found_c && !valid_q[set_c][w]) begin
            inv_found_c = 1'b1;
            vic_c       = WAY_W'(w);
         end
      end
   end

   // Next state, counters and per-line write controls.
   always_comb begin
      state_d     = state_q;
      base_d      = base_q;
      cur_d       = cur_q;
      k_d         = k_q;
      hit_d       = hit_q;
      hit_way_d   = hit_way_q;
      updated_d   = 1'b0;
      found_d     = found_q;
      hit_cnt_d   = hit_cnt_q;
      miss_cnt_d  = miss_cnt_q;
      issue_d     = issue_q;
      useful_d    = useful_q;
      wr_en_c     = 1'b0;
      wr_pf_c     = 1'b0;
      wr_way_c    = vic_c;
      clr_pf_c    = 1'b0;
      touch_c     = 1'b0;
      touch_way_c = hit_way_q;
      case (state_q)
         S_IDLE: begin
            if (trace_ready) begin
               base_d  = mem_addr[addr_w-1:OFF_W];
               cur_d   = mem_addr[addr_w-1:OFF_W];
               state_d = S_LOOKUP;
            end
         end
         S_LOOKUP: begin
            hit_d     = hit_c;
            hit_way_d = hit_way_c;
            state_d   = S_UPDATE;
         end
         S_UPDATE: begin
            updated_d = 1'b1;
            found_d   = hit_q;
            state_d   = S_IDLE;
            if (hit_q) begin
               hit_cnt_d = sat_inc(hit_cnt_q);
               if (pf_q[set_c][hit_way_q]) begin
                  clr_pf_c = 1'b1;
                  useful_d = sat_inc(useful_q);
               end
               touch_c = LRU;
            end else begin
               miss_cnt_d  = sat_inc(miss_cnt_q);
               wr_en_c     = 1'b1;
               touch_c     = 1'b1;
               touch_way_c = vic_c;
               if (PF_EN) begin
                  k_d     = K_W'(1);
                  cur_d   = base_q + BLK_W'(1);
                  state_d = S_PF_LOOK;
               end
            end
         end
         S_PF_LOOK: begin
            hit_d     = hit_c;
            hit_way_d = hit_way_c;
            state_d   = S_PF_FILL;
         end
         S_PF_FILL: begin
            // A resident target is left completely untouched.
            if (!hit_q) begin
               wr_en_c     = 1'b1;
               wr_pf_c     = 1'b1;
               touch_c     = 1'b1;
               touch_way_c = vic_c;
               issue_d     = sat_inc(issue_q);
            end
            k_d = k_q + K_W'(1);
            if (k_d <= K_W'(pf_degree)) begin
               cur_d   = base_q + BLK_W'(k_d);
               state_d = S_PF_LOOK;
            end else begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Recency order with touch_way_c moved to the MRU slot.
   always_comb begin
      pos_c = int'(way) - 1;
      for (int i = 0; i < int'(way); i++) begin
         if (ord_q[set_c][i] == touch_way_c) pos_c = i;
      end
      new_ord_c[0] = touch_way_c;
      for (int i = 1; i < int'(way); i++) begin
         new_ord_c[i] = (i <= pos_c) ? ord_q[set_c][i-1] : ord_q[set_c][i];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= S_IDLE;
         base_q     <= '0;
         cur_q      <= '0;
         k_q        <= '0;
         hit_q      <= 1'b0;
         hit_way_q  <= '0;
         busy_q     <= 1'b0;
         updated_q  <= 1'b0;
         found_q    <= 1'b0;
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
         issue_q    <= '0;
         useful_q   <= '0;
         for (int s = 0; s < int'(SETS); s++) begin
            valid_q[s] <= '0;
            pf_q[s]    <= '0;
            for (int w = 0; w < int'(way); w++) ord_q[s][w] <= WAY_W'(w);
         end
      end else begin
         state_q    <= state_d;
         base_q     <= base_d;
         cur_q      <= cur_d;
         k_q        <= k_d;
         hit_q      <= hit_d;
         hit_way_q  <= hit_way_d;
         busy_q     <= (state_d != S_IDLE);
         updated_q  <= updated_d;
         found_q    <= found_d;
         hit_cnt_q  <= hit_cnt_d;
         miss_cnt_q <= miss_cnt_d;
         issue_q    <= issue_d;
         useful_q   <= useful_d;
         if (wr_en_c) begin
            valid_q[set_c][wr_way_c] <= 1'b1;
            pf_q[set_c][wr_way_c]    <= wr_pf_c;
         end
         if (clr_pf_c) pf_q[set_c][hit_way_q] <= 1'b0;
         if (touch_c) begin
            for (int w = 0; w < int'(way); w++) ord_q[set_c][w] <= new_ord_c[w];
         end
      end
   end

   // Tags need no reset: a line is only looked at once its valid bit is set.
   always_ff @(posedge clk) begin
      if (wr_en_c) tag_q[set_c][wr_way_c] <= tag_c;
   end

   assign busy             = busy_q;
   assign updated          = updated_q;
   assign found_in_cache   = found_q;
   assign cache_hit_count  = hit_cnt_q;
   assign cache_miss_count = miss_cnt_q;
   assign pf_issue_count   = issue_q;
   assign pf_useful_count  = useful_q;
endmodule

// File: tb/tb_cache_sim_pf_core.sv
// Scoreboard bench for cache_sim_pf_core: four configurations exercised one after another.
module tb_cache_sim_pf_core;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        tr  [4];
   logic [31:0] ad  [4];
   logic        bsy [4];
   logic        upd [4];
   logic        fic [4];
   logic [19:0] hc_a, mc_a, pi_a, pu_a;
   logic [3:0]  hc_b, mc_b, pi_b, pu_b;
   logic [19:0] hc_c, mc_c, pi_c, pu_c;
   logic [19:0] hc_d, mc_d, pi_d, pu_d;
   int          h_o [4], m_o [4], pi_o [4], pu_o [4];

   assign h_o[0] = int'(hc_a); assign m_o[0] = int'(mc_a); assign pi_o[0] = int'(pi_a); assign pu_o[0] = int'(pu_a);
   assign h_o[1] = int'(hc_b); assign m_o[1] = int'(mc_b); assign pi_o[1] = int'(pi_b); assign pu_o[1] = int'(pu_b);
   assign h_o[2] = int'(hc_c); assign m_o[2] = int'(mc_c); assign pi_o[2] = int'(pi_c); assign pu_o[2] = int'(pu_c);
   assign h_o[3] = int'(hc_d); assign m_o[3] = int'(mc_d); assign pi_o[3] = int'(pi_d); assign pu_o[3] = int'(pu_d);

   // 0: defaults, 1: no prefetch LRU 4-bit counters, 2: no prefetch FIFO, 3: prefetch degree 2
   cache_sim_pf_core #(.pf_degree(1), .repl_mode(0), .cnt_w(20)) u_a (
      .clk(clk), .reset(rst), .trace_ready(tr[0]), .mem_addr(ad[0]), .busy(bsy[0]), .updated(upd[0]),
      .found_in_cache(fic[0]), .cache_hit_count(hc_a), .cache_miss_count(mc_a),
      .pf_issue_count(pi_a), .pf_useful_count(pu_a));
   cache_sim_pf_core #(.pf_degree(0), .repl_mode(0), .cnt_w(4)) u_b (
      .clk(clk), .reset(rst), .trace_ready(tr[1]), .mem_addr(ad[1]), .busy(bsy[1]), .updated(upd[1]),
      .found_in_cache(fic[1]), .cache_hit_count(hc_b), .cache_miss_count(mc_b),
      .pf_issue_count(pi_b), .pf_useful_count(pu_b));
   cache_sim_pf_core #(.pf_degree(0), .repl_mode(1), .cnt_w(20)) u_c (
      .clk(clk), .reset(rst), .trace_ready(tr[2]), .mem_addr(ad[2]), .busy(bsy[2]), .updated(upd[2]),
      .found_in_cache(fic[2]), .cache_hit_count(hc_c), .cache_miss_count(mc_c),
      .pf_issue_count(pi_c), .pf_useful_count(pu_c));
   cache_sim_pf_core #(.pf_degree(2), .repl_mode(0), .cnt_w(20)) u_d (
      .clk(clk), .reset(rst), .trace_ready(tr[3]), .mem_addr(ad[3]), .busy(bsy[3]), .updated(upd[3]),
      .found_in_cache(fic[3]), .cache_hit_count(hc_d), .cache_miss_count(mc_d),
      .pf_issue_count(pi_d), .pf_useful_count(pu_d));

   typedef struct packed {
      int   id;
      logic hit;
      int   h;
      int   m;
      int   pi;
      int   pu;
   } exp_t;

   exp_t        sb [$];
   exp_t        me;
   int          n_tests;
   int          n_fail;
   logic        upd_prev [4];
   logic [31:0] hs_addr [10];

   function automatic int pfdeg(input int id);
      return (id == 0) ? 1 : (id == 3) ? 2 : 0;
   endfunction

   task automatic cmp(input string nm, input int got, input int exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, got, exp);
      end
   endtask

   // Monitor: every updated pulse pops one expectation and checks flag plus all counters.
   always @(negedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (upd[i] === 1'b1) begin
            cmp($sformatf("dut%0d updated single-cycle", i), int'(upd_prev[i]), 0);
            if (sb.size() == 0) begin
               cmp($sformatf("dut%0d unexpected updated", i), 1, 0);
            end else begin
               me = sb.pop_front();
               cmp($sformatf("dut%0d result owner", i), i, me.id);
               cmp($sformatf("dut%0d found_in_cache", i), int'(fic[i]), int'(me.hit));
               cmp($sformatf("dut%0d hit_count", i), h_o[i], me.h);
               cmp($sformatf("dut%0d miss_count", i), m_o[i], me.m);
               cmp($sformatf("dut%0d pf_issue_count", i), pi_o[i], me.pi);
               cmp($sformatf("dut%0d pf_useful_count", i), pu_o[i], me.pu);
            end
         end
         upd_prev[i] = upd[i];
      end
   end

   task automatic push(input int id, input logic hit, input int h, input int m, input int pi, input int pu);
      exp_t e;
      e.id = id; e.hit = hit; e.h = h; e.m = m; e.pi = pi; e.pu = pu;
      sb.push_back(e);
   endtask

   task automatic wait_idle(input int id);
      int n;
      n = 0;
      while (bsy[id] && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (bsy[id]) cmp($sformatf("dut%0d idle timeout", id), 1, 0);
   endtask

   // One demand access; also measures how long busy stays high.
   task automatic access(input int id, input logic [31:0] a, input logic hit,
                         input int h, input int m, input int pi, input int pu);
      int n;
      wait_idle(id);
      push(id, hit, h, m, pi, pu);
      tr[id] = 1'b1;
      ad[id] = a;
      @(negedge clk);
      tr[id] = 1'b0;
      n = 0;
      while (bsy[id] && n < 100) begin
         n++;
         @(negedge clk);
      end
      cmp($sformatf("dut%0d busy cycles @%h", id, a), n, hit ? 2 : 2 + 2 * pfdeg(id));
   endtask

   task automatic check_zero_a(input string tag);
      cmp({tag, " busy"}, int'(bsy[0]), 0);
      cmp({tag, " updated"}, int'(upd[0]), 0);
      cmp({tag, " found"}, int'(fic[0]), 0);
      cmp({tag, " hit_count"}, h_o[0], 0);
      cmp({tag, " miss_count"}, m_o[0], 0);
      cmp({tag, " pf_issue"}, pi_o[0], 0);
      cmp({tag, " pf_useful"}, pu_o[0], 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      n_tests = 0;
      n_fail  = 0;
      for (int i = 0; i < 4; i++) begin
         tr[i] = 1'b0;
         ad[i] = '0;
         upd_prev[i] = 1'b0;
      end
      hs_addr[0] = 32'h0000_1000; hs_addr[1] = 32'h0000_5550; hs_addr[2] = 32'h0000_7770;
      hs_addr[3] = 32'h0000_1010; hs_addr[4] = 32'h0000_9990; hs_addr[5] = 32'h0000_BBB0;
      hs_addr[6] = 32'h0000_3000; hs_addr[7] = 32'h0000_DDD0; hs_addr[8] = 32'h0000_EEE0;
      hs_addr[9] = 32'h0000_3010;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check_zero_a("reset");
      rst = 1'b0;
      @(negedge clk);

      // Defaults: cold miss prefetches the next line, then useful hits.
      access(0, 32'h0000_1000, 1'b0, 0, 1, 0, 0);
      cmp("dut0 pf_issue after cold miss", pi_o[0], 1);
      access(0, 32'h0000_1010, 1'b1, 1, 1, 1, 1);
      access(0, 32'h0000_1010, 1'b1, 2, 1, 1, 1);
      // Prefetch target already resident: no issue, no later usefulness credit.
      access(0, 32'h0000_3010, 1'b0, 2, 2, 1, 1);
      access(0, 32'h0000_3000, 1'b0, 2, 3, 2, 1);
      cmp("dut0 pf_issue resident target", pi_o[0], 2);
      access(0, 32'h0000_3010, 1'b1, 3, 3, 2, 1);

      // trace_ready held for 10 cycles: accepts land on cycles 0, 3, 6, 9.
      wait_idle(0);
      push(0, 1'b1, 4, 3, 2, 1);
      push(0, 1'b1, 5, 3, 2, 1);
      push(0, 1'b1, 6, 3, 2, 1);
      push(0, 1'b1, 7, 3, 2, 1);
      for (int i = 0; i < 10; i++) begin
         tr[0] = 1'b1;
         ad[0] = hs_addr[i];
         @(negedge clk);
      end
      tr[0] = 1'b0;
      wait_idle(0);
      repeat (2) @(negedge clk);
      cmp("dut0 handshake hit_count", h_o[0], 7);
      cmp("dut0 handshake miss_count", m_o[0], 3);
      cmp("dut0 handshake leftover results", sb.size(), 0);

      // Reset while the prefetch fill is pending.
      push(0, 1'b0, 7, 4, 2, 1);
      tr[0] = 1'b1;
      ad[0] = 32'h0000_5000;
      @(negedge clk);
      tr[0] = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check_zero_a("mid-fill reset");
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      access(0, 32'h0000_1010, 1'b0, 0, 1, 0, 0);
      cmp("dut0 pf_issue after reset", pi_o[0], 1);

      // LRU, no prefetch, set 0 thrash.
      access(1, 32'h0000_0000, 1'b0, 0, 1, 0, 0);
      access(1, 32'h0000_2000, 1'b0, 0, 2, 0, 0);
      access(1, 32'h0000_4000, 1'b0, 0, 3, 0, 0);
      access(1, 32'h0000_6000, 1'b0, 0, 4, 0, 0);
      access(1, 32'h0000_8000, 1'b0, 0, 5, 0, 0);
      access(1, 32'h0000_0000, 1'b0, 0, 6, 0, 0);
      access(1, 32'h0000_8000, 1'b1, 1, 6, 0, 0);
      // 4-bit counters saturate at 15.
      for (int s = 1; s <= 20; s++) begin
         access(1, 32'(s * 16), 1'b0, 1, (6 + s > 15) ? 15 : 6 + s, 0, 0);
      end
      cmp("dut1 saturated miss_count", m_o[1], 15);

      // FIFO: hits on 0x0000 do not protect it from eviction.
      access(2, 32'h0000_0000, 1'b0, 0, 1, 0, 0);
      access(2, 32'h0000_2000, 1'b0, 0, 2, 0, 0);
      access(2, 32'h0000_4000, 1'b0, 0, 3, 0, 0);
      access(2, 32'h0000_6000, 1'b0, 0, 4, 0, 0);
      access(2, 32'h0000_0000, 1'b1, 1, 4, 0, 0);
      access(2, 32'h0000_0000, 1'b1, 2, 4, 0, 0);
      access(2, 32'h0000_8000, 1'b0, 2, 5, 0, 0);
      access(2, 32'h0000_0000, 1'b0, 2, 6, 0, 0);
      access(2, 32'h0000_6000, 1'b1, 3, 6, 0, 0);

      // Degree 2 with address wrap past the top of the space.
      access(3, 32'hFFFF_FFF0, 1'b0, 0, 1, 0, 0);
      cmp("dut3 pf_issue after wrap", pi_o[3], 2);
      access(3, 32'h0000_0000, 1'b1, 1, 1, 2, 1);
      access(3, 32'h0000_0010, 1'b1, 2, 1, 2, 2);

      repeat (4) @(negedge clk);
      cmp("scoreboard drained", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
